inst_fetch_unit: RTL and testbench

//  PC register plus single-outstanding instruction-bus master. Sits upstream of the pipeline controller
//  and feeds the IF/ID latch. Consumes stall_pc/stall_if, flush and exc_pc. Raises fetch_stall_req,

---
 rtl/inst_fetch_unit_pkg.sv | 14 +
 rtl/inst_fetch_unit_next_pc.sv | 23 ++
 rtl/inst_fetch_unit.sv | 127 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, reset PC and fetch state encodings for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic [ADDR_BUS-1:0] INIT_PC = 32'hbfc0_0000;

  localparam logic [1:0] FETCH_ST_REQ     = 2'd0;
  localparam logic [1:0] FETCH_ST_WAIT    = 2'd1;
  localparam logic [1:0] FETCH_ST_HOLD    = 2'd2;
  localparam logic [1:0] FETCH_ST_DISCARD = 2'd3;

endpackage

// File: rtl/inst_fetch_unit_next_pc.sv
// Combinational next-PC selection: taken branch, then pending branch, then sequential pc+4.
module fetch_next_pc
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              branch_pend,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc + ADDR_W'(4);
    if (branch_flag)
      next_pc = branch_addr;
    else if (branch_pend)
      next_pc = pend_addr;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC register and single-outstanding instruction bus master feeding the IF/ID latch.
// Optional fetch address-error detection is enabled with FETCH_ADEL_CHECK_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = INIT_PC,
  parameter int          ADDR_W   = ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_pc,
  input  logic              stall_if,
  input  logic              flush,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic              inst_rvalid,
  input  logic [31:0]       inst_rdata,
  output logic              fetch_stall_req,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_valid,
  output logic              if_exc_adel
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       buffer;
  logic [31:0]       fetch_data;
  logic              branch_pend;
  logic              adel_req;
  logic              avail;
  logic              advance;
  logic              adel_q;

`ifdef FETCH_ADEL_CHECK_EN
  // A misaligned PC never reaches the bus; it is delivered locally as a faulting slot.
  assign adel_req    = (state == FETCH_ST_REQ) && (pc[1:0] != 2'b00);
  assign inst_addr   = pc;
  assign if_exc_adel = adel_q;
`else
  assign adel_req    = 1'b0;
  assign inst_addr   = {pc[ADDR_W-1:2], 2'b00};
  assign if_exc_adel = 1'b0;
`endif

  assign inst_req        = (state == FETCH_ST_REQ) && !adel_req;
  assign avail           = (state == FETCH_ST_HOLD) || ((state == FETCH_ST_WAIT) && inst_rvalid) || adel_req;
  assign fetch_stall_req = !avail;
  assign advance         = avail && !stall_pc && !flush;
  assign fetch_data      = (state == FETCH_ST_HOLD) ? buffer : (adel_req ? 32'h0 : inst_rdata);

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc         (pc),
    .branch_flag(branch_flag),
    .branch_addr(branch_addr),
    .branch_pend(branch_pend),
    .pend_addr  (pend_addr),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_ST_REQ;
      pc          <= ADDR_W'(RESET_PC);
      pend_addr   <= '0;
      branch_pend <= 1'b0;
      buffer      <= '0;
      if_pc       <= '0;
      if_inst     <= '0;
      if_valid    <= 1'b0;
      adel_q      <= 1'b0;
    end else if (flush) begin
      pc          <= exc_pc;
      if_valid    <= 1'b0;
      branch_pend <= 1'b0;
      adel_q      <= 1'b0;
      // Keep draining while a bus response is still owed so it cannot be taken as the new fetch.
      case (state)
        FETCH_ST_REQ:     state <= (inst_ack && !adel_req) ? FETCH_ST_DISCARD : FETCH_ST_REQ;
        FETCH_ST_WAIT:    state <= inst_rvalid ? FETCH_ST_REQ : FETCH_ST_DISCARD;
        FETCH_ST_DISCARD: state <= inst_rvalid ? FETCH_ST_REQ : FETCH_ST_DISCARD;
        default:          state <= FETCH_ST_REQ;
      endcase
    end else if (advance) begin
      if_pc       <= pc;
      if_inst     <= fetch_data;
      if_valid    <= 1'b1;
      adel_q      <= adel_req;
      pc          <= next_pc;
      branch_pend <= 1'b0;
      state       <= FETCH_ST_REQ;
    end else begin
      if (!stall_if)
        if_valid <= 1'b0;
      if (branch_flag) begin
        pend_addr   <= branch_addr;
        branch_pend <= 1'b1;
      end
      case (state)
        FETCH_ST_REQ: begin
          if (inst_ack && !adel_req)
            state <= FETCH_ST_WAIT;
        end
        FETCH_ST_WAIT: begin
          if (inst_rvalid) begin
            buffer <= inst_rdata;
            state  <= FETCH_ST_HOLD;
          end
        end
        FETCH_ST_DISCARD: begin
          if (inst_rvalid)
            state <= FETCH_ST_REQ;
        end
        default: state <= FETCH_ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with hand-computed expectations.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_pc, stall_if, flush, branch_flag;
  logic [31:0] exc_pc, branch_addr;
  logic        inst_req, inst_ack, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata;
  logic        fetch_stall_req;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, if_exc_adel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_pc       (stall_pc),
    .stall_if       (stall_if),
    .flush          (flush),
    .exc_pc         (exc_pc),
    .branch_flag    (branch_flag),
    .branch_addr    (branch_addr),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_ack       (inst_ack),
    .inst_rvalid    (inst_rvalid),
    .inst_rdata     (inst_rdata),
    .fetch_stall_req(fetch_stall_req),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid),
    .if_exc_adel    (if_exc_adel)
  );

  // Advance one clock; inputs are changed and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_pc = 1'b0; stall_if = 1'b0; flush = 1'b0; exc_pc = '0;
    branch_flag = 1'b0; branch_addr = '0; inst_ack = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0;
    step();
    vectors++;
    if ({if_valid, if_exc_adel} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL reset_valid got %b want 00", {if_valid, if_exc_adel});
    end
    vectors++;
    if ({if_pc, if_inst} !== 64'h0) begin
      miscompares++; $display("[TB] FAIL reset_if got %h want 0", {if_pc, if_inst});
    end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000 || fetch_stall_req !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_bus got req=%b addr=%h stall=%b want 1 bfc00000 1", inst_req, inst_addr, fetch_stall_req);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    inst_ack = 1'b1;
    #1;
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000) begin
      miscompares++; $display("[TB] FAIL first_req got req=%b addr=%h want 1 bfc00000", inst_req, inst_addr);
    end
    step();
    inst_ack = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'h2408_0001;
    #1;
    vectors++;
    if (fetch_stall_req !== 1'b0) begin
      miscompares++; $display("[TB] FAIL first_avail got stall=%b want 0", fetch_stall_req);
    end
    step();
    inst_rvalid = 1'b0;
    vectors++;
    if (if_pc !== 32'hbfc0_0000 || if_inst !== 32'h2408_0001 || if_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL first_if got pc=%h inst=%h v=%b want bfc00000 24080001 1", if_pc, if_inst, if_valid);
    end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0004 || fetch_stall_req !== 1'b1) begin
      miscompares++; $display("[TB] FAIL first_next got req=%b addr=%h stall=%b want 1 bfc00004 1", inst_req, inst_addr, fetch_stall_req);
    end
  endtask

  task automatic test_stall_hold();
    inst_ack = 1'b1; stall_pc = 1'b1; stall_if = 1'b1;
    step();
    inst_ack = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'h8c09_0004;
    step();
    inst_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (if_pc !== 32'hbfc0_0000 || if_inst !== 32'h2408_0001 || if_valid !== 1'b1) begin
        miscompares++; $display("[TB] FAIL hold_if[%0d] got pc=%h inst=%h v=%b want bfc00000 24080001 1", i, if_pc, if_inst, if_valid);
      end
      vectors++;
      if (inst_req !== 1'b0 || fetch_stall_req !== 1'b0) begin
        miscompares++; $display("[TB] FAIL hold_bus[%0d] got req=%b stall=%b want 0 0", i, inst_req, fetch_stall_req);
      end
      if (i < 2) step();
    end
    stall_pc = 1'b0; stall_if = 1'b0;
    step();
    vectors++;
    if (if_pc !== 32'hbfc0_0004 || if_inst !== 32'h8c09_0004 || if_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL hold_release got pc=%h inst=%h v=%b want bfc00004 8c090004 1", if_pc, if_inst, if_valid);
    end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0008) begin
      miscompares++; $display("[TB] FAIL hold_next got req=%b addr=%h want 1 bfc00008", inst_req, inst_addr);
    end
  endtask

  task automatic test_flush_discard();
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0; flush = 1'b1; exc_pc = 32'hbfc0_0380;
    step();
    flush = 1'b0;
    vectors++;
    if (if_valid !== 1'b0 || inst_req !== 1'b0 || fetch_stall_req !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_drain got v=%b req=%b stall=%b want 0 0 1", if_valid, inst_req, fetch_stall_req);
    end
    step();
    inst_rvalid = 1'b1; inst_rdata = 32'hdead_beef;
    #1;
    vectors++;
    if (fetch_stall_req !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_stale_avail got stall=%b want 1", fetch_stall_req);
    end
    step();
    inst_rvalid = 1'b0;
    vectors++;
    if (if_valid !== 1'b0 || if_inst !== 32'h8c09_0004) begin
      miscompares++; $display("[TB] FAIL flush_dropped got v=%b inst=%h want 0 8c090004", if_valid, if_inst);
    end
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0380) begin
      miscompares++; $display("[TB] FAIL flush_target got req=%b addr=%h want 1 bfc00380", inst_req, inst_addr);
    end
  endtask

  task automatic test_branch_pending();
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0; stall_pc = 1'b1; stall_if = 1'b1; inst_rvalid = 1'b1; inst_rdata = 32'h0000_0001;
    branch_flag = 1'b1; branch_addr = 32'hbfc0_0100;
    step();
    branch_flag = 1'b0; inst_rvalid = 1'b0;
    step();
    stall_pc = 1'b0; stall_if = 1'b0;
    step();
    vectors++;
    if (if_pc !== 32'hbfc0_0380 || if_inst !== 32'h0000_0001 || if_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL branch_if got pc=%h inst=%h v=%b want bfc00380 00000001 1", if_pc, if_inst, if_valid);
    end
    vectors++;
    if (inst_addr !== 32'hbfc0_0100) begin
      miscompares++; $display("[TB] FAIL branch_target got addr=%h want bfc00100", inst_addr);
    end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'h0000_0002;
    step();
    inst_rvalid = 1'b0;
    vectors++;
    if (if_pc !== 32'hbfc0_0100 || if_inst !== 32'h0000_0002) begin
      miscompares++; $display("[TB] FAIL branch_fetch got pc=%h inst=%h want bfc00100 00000002", if_pc, if_inst);
    end
    vectors++;
    if (inst_addr !== 32'hbfc0_0104) begin
      miscompares++; $display("[TB] FAIL branch_cleared got addr=%h want bfc00104", inst_addr);
    end
  endtask

  task automatic test_pc_wrap();
    flush = 1'b1; exc_pc = 32'hffff_fffc;
    step();
    flush = 1'b0;
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hffff_fffc) begin
      miscompares++; $display("[TB] FAIL wrap_req got req=%b addr=%h want 1 fffffffc", inst_req, inst_addr);
    end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'h0000_0003;
    step();
    inst_rvalid = 1'b0;
    vectors++;
    if (if_pc !== 32'hffff_fffc || if_inst !== 32'h0000_0003 || if_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL wrap_if got pc=%h inst=%h v=%b want fffffffc 00000003 1", if_pc, if_inst, if_valid);
    end
    vectors++;
    if (inst_addr !== 32'h0000_0000) begin
      miscompares++; $display("[TB] FAIL wrap_next got addr=%h want 00000000", inst_addr);
    end
  endtask

`ifdef FETCH_ADEL_CHECK_EN
  task automatic test_addr_error();
    flush = 1'b1; exc_pc = 32'hbfc0_0002;
    step();
    flush = 1'b0;
    vectors++;
    if (inst_req !== 1'b0 || fetch_stall_req !== 1'b0) begin
      miscompares++; $display("[TB] FAIL adel_noreq got req=%b stall=%b want 0 0", inst_req, fetch_stall_req);
    end
    step();
    vectors++;
    if (if_exc_adel !== 1'b1 || if_inst !== 32'h0 || if_pc !== 32'hbfc0_0002 || if_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL adel_if got adel=%b inst=%h pc=%h v=%b want 1 0 bfc00002 1", if_exc_adel, if_inst, if_pc, if_valid);
    end
  endtask
`else
  task automatic test_addr_error();
    flush = 1'b1; exc_pc = 32'hbfc0_0002;
    step();
    flush = 1'b0;
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000 || if_exc_adel !== 1'b0) begin
      miscompares++; $display("[TB] FAIL align_force got req=%b addr=%h adel=%b want 1 bfc00000 0", inst_req, inst_addr, if_exc_adel);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_flush_discard();
    test_branch_pending();
    test_pc_wrap();
    test_addr_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
